imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 126 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate decoder with sign extension and a DEPTH-entry output FIFO (1-cycle latency).
// Optional saturating illegal-encoding counter enabled by IMM_EXTEND_ERR_CNT_EN.
module imm_extend_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ImmOp,
    output logic             illegal,
    output logic [7:0]       err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]      imm32;
    logic [WIDTH-1:0] dec_imm;
    logic             dec_ill;

    logic [WIDTH-1:0] imm_mem_q [DEPTH];
    logic             ill_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop;

    always_comb begin
        imm32   = '0;
        dec_ill = 1'b0;
        case (ImmSrc)
            3'd0:    imm32 = {{20{instr[31]}}, instr[31:20]};
            3'd1:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            3'd3:    imm32 = {instr[31:12], 12'b0};
            3'd4:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: dec_ill = 1'b1;
        endcase
        // Bit 31 of imm32 is always instr[31] for legal codes, so widening as signed
        // gives the required sign extension, including U-type at 64 bits.
        dec_imm = WIDTH'($signed(imm32));
    end

    assign out_valid = (cnt_q != '0);
    assign in_ready  = in_ready_q;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Registered so out_ready never reaches in_ready combinationally; a pop while
        // full therefore only reopens the input on the following cycle.
        in_ready_d = (cnt_d < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem_q[wr_ptr_q] <= dec_ill ? '0 : dec_imm;
            ill_mem_q[wr_ptr_q] <= dec_ill;
        end
    end

    assign ImmOp   = out_valid ? imm_mem_q[rd_ptr_q] : '0;
    assign illegal = out_valid ? ill_mem_q[rd_ptr_q] : 1'b0;

`ifdef IMM_EXTEND_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && dec_ill && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, scoreboard queue and
// hand-written backpressure / illegal / reset sequences.
module tb_imm_extend_pipe;

    localparam int DEPTH  = 2;
    localparam int NVEC   = 13;
    localparam int ILL7   = 12;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] ins;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ImmOp;
    logic        illegal;
    logic [7:0]  err_cnt;

    logic        iv64, ir64, ov64, or64, ill64;
    logic [63:0] imm64;
    logic [7:0]  err64;

    vec_t        vecs [NVEC];
    logic [32:0] exp_q [$];
    logic [32:0] exp_cur;
    int          err_exp;
    logic        seen_edge;
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .ImmSrc(ImmSrc), .out_valid(out_valid), .out_ready(out_ready),
        .ImmOp(ImmOp), .illegal(illegal), .err_cnt(err_cnt)
    );

    imm_extend_pipe #(.WIDTH(64), .DEPTH(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .instr(instr), .ImmSrc(ImmSrc), .out_valid(ov64), .out_ready(or64),
        .ImmOp(imm64), .illegal(ill64), .err_cnt(err64)
    );

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_edge <= 1'b0;
        else        seen_edge <= 1'b1;
    end

    // Scoreboard: check head against model queue, then apply the handshakes
    // that will take effect at the coming rising edge.
    always @(negedge clk) begin
        logic model_ready;
        logic [7:0] err_want;
        if (!rst_n) begin
            exp_q.delete();
            err_exp = 0;
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_imm", {32'd0, ImmOp}, 64'd0);
            chk("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
        end else begin
            model_ready = seen_edge && (exp_q.size() < DEPTH);
`ifdef IMM_EXTEND_ERR_CNT_EN
            err_want = 8'(err_exp);
`else
            err_want = 8'd0;
`endif
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, model_ready});
            chk("err_cnt", {56'd0, err_cnt}, {56'd0, err_want});
            if (exp_q.size() == 0) begin
                chk("empty_imm", {32'd0, ImmOp}, 64'd0);
                chk("empty_illegal", {63'd0, illegal}, 64'd0);
            end else begin
                chk("head_imm", {32'd0, ImmOp}, {32'd0, exp_q[0][31:0]});
                chk("head_illegal", {63'd0, illegal}, {63'd0, exp_q[0][32]});
            end
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && model_ready) begin
                exp_q.push_back(exp_cur);
                if (exp_cur[32] && err_exp < 255) err_exp++;
            end
        end
    end

    task automatic drive(input int idx);
        in_valid = 1'b1;
        instr    = vecs[idx].ins;
        ImmSrc   = vecs[idx].src;
        exp_cur  = {vecs[idx].ill, vecs[idx].imm};
    endtask

    task automatic send(input int idx);
        int n = 0;
        drive(idx);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'hFFF00093, 32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{3'd1, 32'hFE112E23, 32'hFFFFFFFC, 1'b0};
        vecs[2]  = '{3'd2, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0};
        vecs[3]  = '{3'd3, 32'h12345037, 32'h12345000, 1'b0};
        vecs[4]  = '{3'd4, 32'h0080006F, 32'h00000008, 1'b0};
        vecs[5]  = '{3'd0, 32'h00500093, 32'h00000005, 1'b0};
        vecs[6]  = '{3'd1, 32'h00112423, 32'h00000008, 1'b0};
        vecs[7]  = '{3'd2, 32'h00000463, 32'h00000008, 1'b0};
        vecs[8]  = '{3'd3, 32'hFFFFF037, 32'hFFFFF000, 1'b0};
        vecs[9]  = '{3'd4, 32'hFFDFF06F, 32'hFFFFFFFC, 1'b0};
        vecs[10] = '{3'd5, 32'h12345678, 32'h00000000, 1'b1};
        vecs[11] = '{3'd6, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[12] = '{3'd7, 32'h80000000, 32'h00000000, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; ImmSrc = '0; exp_cur = '0;
        iv64 = 1'b0; or64 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 64-bit U-type sign extension
        instr = 32'h80000037; ImmSrc = 3'd3; iv64 = 1'b1;
        @(negedge clk);
        chk("w64_in_ready", {63'd0, ir64}, 64'd1);
        @(posedge clk); #1 iv64 = 1'b0;
        @(negedge clk);
        chk("w64_out_valid", {63'd0, ov64}, 64'd1);
        chk("w64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("w64_illegal", {63'd0, ill64}, 64'd0);
        @(posedge clk); #1;

        // Format table, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) send(i);
        repeat (3) begin @(posedge clk); #1; end

        // Backpressure with three back-to-back inputs
        out_ready = 1'b0;
        send(0);
        send(1);
        drive(2);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
            chk("bp_head_stable", {32'd0, ImmOp}, {32'd0, vecs[0].imm});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_during_pop", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end

        // Illegal encoding stream and counter saturation
        for (int k = 0; k < 300; k++) send(ILL7);
        repeat (3) begin @(posedge clk); #1; end
`ifdef IMM_EXTEND_ERR_CNT_EN
        chk("err_cnt_saturated", {56'd0, err_cnt}, 64'd255);
`else
        chk("err_cnt_tied", {56'd0, err_cnt}, 64'd0);
`endif

        // Reset while full
        out_ready = 1'b0;
        send(3);
        send(4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_imm", {32'd0, ImmOp}, 64'd0);
        chk("midrst_illegal", {63'd0, illegal}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst_err_cnt", {56'd0, err_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("postrst_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        send(9);
        repeat (3) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
